// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising per-core data-memory requests onto one
// single-port synchronous memory, plus the run/done controller for the cores.
module dm_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          start,
   input  logic [NUM_CORES-1:0]          core_req,
   input  logic [NUM_CORES-1:0]          core_we,
   input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
   input  logic [NUM_CORES-1:0]          core_done,
   output logic [2*NUM_CORES-1:0]        core_status,
   output logic [NUM_CORES-1:0]          core_ack,
   output logic [DATA_W-1:0]             core_rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          all_done
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      RUN_IDLE   = 2'd0,
      RUN_ACTIVE = 2'd1,
      RUN_DONE   = 2'd2
   } run_state_e;

   typedef enum logic [1:0] {
      ARB_GRANT = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   run_state_e            run_q, run_d;
   arb_state_e            arb_q, arb_d;
   logic [NUM_CORES-1:0]  done_lat_q, done_lat_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]         g_q, g_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NUM_CORES-1:0]  core_ack_q, core_ack_d;
   logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;
   logic                  all_done_q, all_done_d;

   logic [NUM_CORES-1:0]  elig;
   logic                  win_vld;
   logic [PW-1:0]         win_idx;
   logic [PW-1:0]         idx;

   // The core acked this cycle is masked so its still-held request is not served twice.
   always_comb begin
      elig    = core_req & ~done_lat_q & ~core_ack_q;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr_q) + k) % NUM_CORES);
         if (elig[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   always_comb begin
      run_d        = run_q;
      arb_d        = arb_q;
      done_lat_d   = done_lat_q;
      rr_ptr_d     = rr_ptr_q;
      g_d          = g_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      core_ack_d   = '0;
      core_rdata_d = core_rdata_q;

      case (run_q)
         RUN_IDLE:   if (start) run_d = RUN_ACTIVE;
         RUN_ACTIVE: if (&done_lat_q) run_d = RUN_DONE;
         RUN_DONE:   if (start) run_d = RUN_ACTIVE;
         default:    run_d = RUN_IDLE;
      endcase

      if (run_q == RUN_ACTIVE) done_lat_d = done_lat_q | core_done;

      // ISSUE and RESP always run to completion so an in-flight access is acked.
      case (arb_q)
         ARB_GRANT: begin
            if (run_q == RUN_ACTIVE && win_vld) begin
               g_d         = win_idx;
               mem_en_d    = 1'b1;
               mem_we_d    = core_we[win_idx];
               mem_addr_d  = core_addr[win_idx*ADDR_W +: ADDR_W];
               mem_wdata_d = core_wdata[win_idx*DATA_W +: DATA_W];
               arb_d       = ARB_ISSUE;
            end
         end
         ARB_ISSUE: arb_d = ARB_RESP;
         ARB_RESP: begin
            core_rdata_d    = mem_rdata;
            core_ack_d[g_q] = 1'b1;
            rr_ptr_d        = (g_q == PW'(NUM_CORES - 1)) ? '0 : g_q + 1'b1;
            arb_d           = ARB_GRANT;
         end
         default: arb_d = ARB_GRANT;
      endcase

      if (run_q == RUN_DONE && start) begin
         done_lat_d = '0;
         rr_ptr_d   = '0;
      end

      all_done_d = (run_d == RUN_DONE);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         run_q        <= RUN_IDLE;
         arb_q        <= ARB_GRANT;
         done_lat_q   <= '0;
         rr_ptr_q     <= '0;
         g_q          <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_ack_q   <= '0;
         core_rdata_q <= '0;
         all_done_q   <= 1'b0;
      end else begin
         run_q        <= run_d;
         arb_q        <= arb_d;
         done_lat_q   <= done_lat_d;
         rr_ptr_q     <= rr_ptr_d;
         g_q          <= g_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_ack_q   <= core_ack_d;
         core_rdata_q <= core_rdata_d;
         all_done_q   <= all_done_d;
      end
   end

   always_comb begin
      core_status = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (done_lat_q[i])                      core_status[2*i +: 2] = 2'b11;
         else if (run_q == RUN_IDLE)             core_status[2*i +: 2] = 2'b00;
         else if (core_req[i] && !core_ack_q[i]) core_status[2*i +: 2] = 2'b10;
         else                                    core_status[2*i +: 2] = 2'b01;
      end
   end

   assign core_ack   = core_ack_q;
   assign core_rdata = core_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign all_done   = all_done_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shared data-memory arbiter and run controller for the multicore matrix-multiply array. It sits directly upstream of the `processor_d`-class cores and drives each core's `status` code. It accepts per-core data-memory requests, serialises them onto one single-port synchronous data memory in round-robin order, and returns read data. It also latches each core's `end_process` and raises `all_done` once every core has finished.

## Interface
Parameters:
- NUM_CORES, 4, number of attached cores (2..8)
- DATA_W, 16, data word width
- ADDR_W, 16, data-memory address width

Ports:
- clock  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE or DONE
- core_req  in  NUM_CORES  per-core access request; core holds it, and its operands, until its ack
- core_we  in  NUM_CORES  per-core write qualifier (1 = write, 0 = read)
- core_addr  in  NUM_CORES*ADDR_W  per-core address (`ar_out`), core i at bits [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  per-core write data (`r2_out`), same packing
- core_done  in  NUM_CORES  per-core `end_process`
- core_status  out  2*NUM_CORES  per-core status code, core i at bits [2i+1:2i]
- core_ack  out  NUM_CORES  one-cycle completion pulse per core
- core_rdata  out  DATA_W  shared read-data bus; valid for the core whose ack is high
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid one cycle after mem_en
- all_done  out  1  high while in DONE

## Operation
- Run FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → DONE when all done latches are set.
  - DONE → RUN on start; this clears the done latches and resets rr_ptr to 0.
  - start is ignored in RUN.
- Status code per core i:
  - 11 (DONE) if done_lat[i] is set.
  - else 00 (IDLE) in IDLE.
  - else 10 (STALL) if core_req[i]=1 and core_ack[i]=0.
  - else 01 (RUN).
  - Status is combinational from registered state and core_req.
- done_lat[i] sets when core_done[i]=1 in RUN and stays set until start is honoured or rst.
- Arbiter FSM: GRANT → ISSUE → RESP → GRANT. It is active only in RUN and holds in GRANT otherwise.
- GRANT:
  - Eligible cores have core_req=1, done_lat=0 and core_ack=0. The just-acked core is masked so that a held request is never granted twice.
  - The winner is the first eligible index at or after rr_ptr, searching upward mod NUM_CORES.
  - On a winner: register g, mem_we, mem_addr and mem_wdata from core g; go to ISSUE.
  - With no eligible core, stay in GRANT.
- ISSUE: mem_en=1 with registered operands; go to RESP.
- RESP:
  - Capture mem_rdata into core_rdata (captured for writes too; the value is don't-care).
  - Set core_ack[g] for the next cycle.
  - rr_ptr ← (g+1) mod NUM_CORES.
  - Go to GRANT.
- A core that sets its done latch while requesting but not granted has its request dropped. An in-flight access completes and is still acked.

## Timing
- Reset values: all outputs 0 and core_status all 00. State is IDLE/GRANT, rr_ptr=0, done latches clear.
- Access latency, with request seen in GRANT at cycle c:
  - mem_en high in c+1.
  - mem_rdata sampled at the end of c+2.
  - core_ack and core_rdata valid in c+3, which is also the next GRANT cycle.
- Peak throughput is one access per 3 cycles.
- mem_en, mem_we, mem_addr and mem_wdata are registered. mem_en is high only in ISSUE; mem_we=0 whenever mem_en=0.
- core_ack is a single-cycle pulse with at most one bit set. core_rdata holds its value until the next RESP.
- all_done rises the cycle after the last done latch sets.
- rst asserted in any state:
  - The next cycle is the reset state.
  - An in-flight access is abandoned: no mem_en after rst, and no ack.
- start and rst in the same cycle: rst wins.

## Test plan
- Reset, start, then core 2 reads 0x0010 with the memory returning 0x1234: mem_en=1 and mem_addr=0x0010 in c+1; core_ack[2]=1 and core_rdata=0x1234 in c+3; status[2]=10 in c..c+2 and 01 in c+3.
- All four cores request at once with rr_ptr=0 and hold until acked: grants go 0,1,2,3, with acks at c+3, c+6, c+9, c+12; no core is ever acked twice.
- Cores 0 and 3 re-request immediately after each ack: grant order is 0,3,0,3 (wrap from 3 to 0); rr_ptr=1 after a core-0 grant.
- Core 1 writes 0xBEEF to 0x0020: exactly one cycle with mem_en=1, mem_we=1, mem_addr=0x0020, mem_wdata=0xBEEF; ack at c+3.
- core_done is pulsed on cores 3,0,2,1 at different cycles: each status goes to 11 permanently; all_done=1 the cycle after core 1; start then returns all statuses to 01 and all_done to 0.
- rst during ISSUE: next cycle mem_en=0, all statuses 00, no core_ack is ever produced for the aborted access, and a start afterwards serves requests normally.
